gshare_branch_predictor: RTL

Parametrised direction predictor for the ID stage. It is the successor to the PC-indexed bimodal history table: it adds a speculative global history register (GHR) that is XOR-folded into the table index, plus mispredict recovery of that history from EX. A reset sweep FSM clears the counter table one entry per cycle, so the table maps to RAM rather than flops. The block sits between ID, which queries it and carries the history snapshot down the pipe, and EX, which resolves branches and updates the table.

---
 rtl/gshare_branch_predictor.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/gshare_branch_predictor.sv
// -----------------------------------------------------------------------------
// gshare_branch_predictor
//
// Direction predictor for the ID stage. A table of saturating counters is
// indexed by the branch PC XOR-folded with a speculative global history
// register (GHR). EX resolves branches, trains the table and repairs the GHR
// on a mispredict. After reset a sweep FSM writes INIT_CTR into every table
// entry, one per cycle, so the table has no reset and can map onto RAM.
//
// Build option:
//   BHT_GSHARE_EN  defined   : gshare indexing with speculative GHR and recovery
//                  undefined : plain bimodal (PC-only index, no GHR,
//                              pred_hist tied to 0, ex_hist/ex_mispredict unused)
//
// Ports:
//   clk            clock, all state on the rising edge
//   rst            synchronous active-high reset, restarts the clear sweep
//   ready          high once every table entry has been initialised
//   id_valid       ID consumes a prediction this cycle (shifts the GHR)
//   id_pc          PC of the ID branch
//   pred_taken     predicted direction (combinational)
//   pred_hist      GHR used for this prediction, carried down the pipe to EX
//   ex_update      EX resolved a branch this cycle
//   ex_pc          PC of the resolved branch
//   ex_hist        pred_hist captured when that branch was predicted
//   ex_taken       resolved direction
//   ex_mispredict  resolved direction differed from the prediction
// -----------------------------------------------------------------------------
module gshare_branch_predictor #(
  parameter int CTR_BITS   = 2,
  parameter int TABLE_SIZE = 1024,
  parameter int HIST_BITS  = 10,
  parameter int INIT_CTR   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic                 id_valid,
  input  logic [31:0]          id_pc,
  output logic                 pred_taken,
  output logic [HIST_BITS-1:0] pred_hist,
  input  logic                 ex_update,
  input  logic [31:0]          ex_pc,
  input  logic [HIST_BITS-1:0] ex_hist,
  input  logic                 ex_taken,
  input  logic                 ex_mispredict
);

  localparam int TABLE_BITS = $clog2(TABLE_SIZE);

  localparam logic [CTR_BITS-1:0]   CTR_INIT = CTR_BITS'(INIT_CTR);
  localparam logic [CTR_BITS-1:0]   CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]   CTR_MIN  = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0]   CTR_ONE  = CTR_BITS'(1'b1);
  localparam logic [TABLE_BITS-1:0] IDX_ONE  = TABLE_BITS'(1'b1);
  localparam logic [TABLE_BITS-1:0] IDX_LAST = TABLE_BITS'(TABLE_SIZE - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Saturating counter step; a counter already at its limit stays put.
  function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] ctr,
                                                   input logic                taken);
    logic [CTR_BITS-1:0] res;
    if (taken && (ctr != CTR_MAX)) begin
      res = ctr + CTR_ONE;
    end else if (!taken && (ctr != CTR_MIN)) begin
      res = ctr - CTR_ONE;
    end else begin
      res = ctr;
    end
    return res;
  endfunction

`ifdef BHT_GSHARE_EN
  // Shift one outcome into the low end of a history value. Written with a
  // shift rather than a slice so that HIST_BITS = 1 degenerates cleanly.
  function automatic logic [HIST_BITS-1:0] hist_push(input logic [HIST_BITS-1:0] h,
                                                     input logic                 b);
    logic [HIST_BITS-1:0] res;
    res    = h << 1'b1;
    res[0] = b;
    return res;
  endfunction

  // Word-aligned PC bits XOR the zero-extended history (history in the low bits).
  function automatic logic [TABLE_BITS-1:0] table_idx(input logic [31:0]          pc,
                                                      input logic [HIST_BITS-1:0] h);
    return pc[TABLE_BITS+1:2] ^ TABLE_BITS'(h);
  endfunction
`else
  // Bimodal: index from word-aligned PC bits only.
  function automatic logic [TABLE_BITS-1:0] table_idx(input logic [31:0] pc);
    return pc[TABLE_BITS+1:2];
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_r;
  state_e                  state_nxt_s;
  logic [TABLE_BITS-1:0]   sweep_idx_r;
  logic [TABLE_BITS-1:0]   sweep_idx_nxt_s;
  logic [CTR_BITS-1:0]     ctr_table_r [TABLE_SIZE];

  logic                    run_s;
  logic [TABLE_BITS-1:0]   q_idx_s;
  logic [TABLE_BITS-1:0]   u_idx_s;
  logic [CTR_BITS-1:0]     q_ctr_s;
  logic [CTR_BITS-1:0]     u_ctr_s;
  logic                    wr_en_s;
  logic [TABLE_BITS-1:0]   wr_idx_s;
  logic [CTR_BITS-1:0]     wr_data_s;
  logic [HIST_BITS-1:0]    hist_s;

  // Sweep FSM next state: CLEAR walks every entry once, then settles in RUN.
  always_comb begin
    state_nxt_s     = state_r;
    sweep_idx_nxt_s = sweep_idx_r;
    case (state_r)
      ST_CLEAR: begin
        sweep_idx_nxt_s = sweep_idx_r + IDX_ONE;
        if (sweep_idx_r == IDX_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RUN: begin
        state_nxt_s     = ST_RUN;
        sweep_idx_nxt_s = sweep_idx_r;
      end
      default: begin
        state_nxt_s     = ST_CLEAR;
        sweep_idx_nxt_s = {TABLE_BITS{1'b0}};
      end
    endcase
  end

  // Sweep FSM state register; reset restarts the sweep at entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_CLEAR;
      sweep_idx_r <= {TABLE_BITS{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      sweep_idx_r <= sweep_idx_nxt_s;
    end
  end

  assign run_s = (state_r == ST_RUN);
  assign ready = run_s;

  // ---------------------------------------------------------------------------
  // Global history
  // ---------------------------------------------------------------------------
`ifdef BHT_GSHARE_EN
  logic [HIST_BITS-1:0] ghr_r;
  logic [HIST_BITS-1:0] ghr_nxt_s;

  // GHR next value: EX recovery beats the speculative shift (ID gets flushed);
  // nothing moves the history while the table is still being cleared.
  always_comb begin
    ghr_nxt_s = ghr_r;
    if (run_s && ex_update && ex_mispredict) begin
      ghr_nxt_s = hist_push(ex_hist, ex_taken);
    end else if (run_s && id_valid) begin
      ghr_nxt_s = hist_push(ghr_r, pred_taken);
    end else begin
      ghr_nxt_s = ghr_r;
    end
  end

  // GHR register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_r <= {HIST_BITS{1'b0}};
    end else begin
      ghr_r <= ghr_nxt_s;
    end
  end

  assign hist_s  = ghr_r;
  assign q_idx_s = table_idx(id_pc, ghr_r);
  assign u_idx_s = table_idx(ex_pc, ex_hist);

  // Upper/lower PC bits never reach the index.
  logic unused_s;
  assign unused_s = ^{id_pc[31:TABLE_BITS+2], id_pc[1:0],
                      ex_pc[31:TABLE_BITS+2], ex_pc[1:0]};
`else
  assign hist_s  = {HIST_BITS{1'b0}};
  assign q_idx_s = table_idx(id_pc);
  assign u_idx_s = table_idx(ex_pc);

  // Without history these inputs carry no information for the predictor.
  logic unused_s;
  assign unused_s = ^{id_pc[31:TABLE_BITS+2], id_pc[1:0],
                      ex_pc[31:TABLE_BITS+2], ex_pc[1:0],
                      id_valid, ex_hist, ex_mispredict};
`endif

  // ---------------------------------------------------------------------------
  // Counter table
  // ---------------------------------------------------------------------------
  // Asynchronous read ports: query returns the pre-update value on a same-index
  // collision because the write lands at the edge.
  assign q_ctr_s = ctr_table_r[q_idx_s];
  assign u_ctr_s = ctr_table_r[u_idx_s];

  // Single table write port: sweep write in CLEAR, EX training write in RUN.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = sweep_idx_r;
    wr_data_s = CTR_INIT;
    if (rst) begin
      wr_en_s = 1'b0;
    end else if (!run_s) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = sweep_idx_r;
      wr_data_s = CTR_INIT;
    end else if (ex_update) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = u_idx_s;
      wr_data_s = ctr_step(u_ctr_s, ex_taken);
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Table storage; no reset so it can be implemented as RAM.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      ctr_table_r[wr_idx_s] <= wr_data_s;
    end
  end

  // Prediction outputs are held at 0 until the sweep has finished.
  always_comb begin
    pred_taken = 1'b0;
    pred_hist  = {HIST_BITS{1'b0}};
    if (run_s) begin
      pred_taken = q_ctr_s[CTR_BITS-1];
      pred_hist  = hist_s;
    end else begin
      pred_taken = 1'b0;
      pred_hist  = {HIST_BITS{1'b0}};
    end
  end

endmodule
